// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding, error codes and defaults for the memory access controller
package mem_ctrl_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RW       = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt: clearable saturating counter that flags expiry at MAX-1
module mem_timeout_cnt #(
  parameter int MAX = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int W = MAX > 1 ? $clog2(MAX) : 1;
  logic [W-1:0] cnt;
  assign expired_o = cnt == W'(MAX - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else if (clr_i) cnt <= '0;
    else if (en_i && !expired_o) cnt <= cnt + W'(1);
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage bridge that stalls the pipeline while a single word access completes
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          TIMEOUT   = TIMEOUT_DEF,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic [1:0]  err_o,
  output logic        mreq_o,
  output logic        mwe_o,
  output logic [31:0] maddr_o,
  output logic [31:0] mwdata_o,
  input  logic        mack_i,
  input  logic [31:0] mrdata_i
);
  state_t state;
  logic any_req, misalign, rw_both, valid, expired;
  assign any_req  = mem_read_i | mem_write_i;
  assign misalign = any_req && addr_i[1:0] != 2'b00;
  assign rw_both  = mem_read_i && mem_write_i;
  assign valid    = any_req && !misalign && !rw_both;
  // the pipeline advances on the same edge that ends the access, whether by ack or abort
  assign stall_o  = state == IDLE ? valid : !mack_i && !expired;
  mem_timeout_cnt #(.MAX(TIMEOUT)) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (state == IDLE),
    .en_i     (!mack_i),
    .expired_o(expired)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      mreq_o   <= 1'b0;
      mwe_o    <= 1'b0;
      maddr_o  <= '0;
      mwdata_o <= '0;
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
      err_o    <= ERR_NONE;
    end else begin
      rvalid_o <= 1'b0;
      if (state == IDLE) begin
        if (valid) begin
          state    <= WAIT;
          mreq_o   <= 1'b1;
          mwe_o    <= mem_write_i;
          maddr_o  <= {addr_i[31:2], 2'b00};
          mwdata_o <= wdata_i;
        end else if (err_o == ERR_NONE && misalign) err_o <= ERR_MISALIGN;
        else if (err_o == ERR_NONE && rw_both) err_o <= ERR_RW;
      end else if (mack_i || expired) begin
        state  <= IDLE;
        mreq_o <= 1'b0;
        mwe_o  <= 1'b0;
        if (!mwe_o) begin
          rdata_o  <= mack_i ? mrdata_i : ERR_RDATA;
          rvalid_o <= 1'b1;
        end
        if (!mack_i && err_o == ERR_NONE) err_o <= ERR_TIMEOUT;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed vectors with hand-computed expectations for mem_access_ctrl
module tb_mem_access_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rvalid_o;
  logic [1:0]  err_o;
  logic        mreq_o;
  logic        mwe_o;
  logic [31:0] maddr_o;
  logic [31:0] mwdata_o;
  logic        mack_i = 1'b0;
  logic [31:0] mrdata_i = '0;
  int n_cmp = 0;
  int n_err = 0;
  int sc, rc, n;
  logic stall_last;
  mem_access_ctrl #(.TIMEOUT(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mem_read_i (mem_read_i),
    .mem_write_i(mem_write_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .stall_o    (stall_o),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .err_o      (err_o),
    .mreq_o     (mreq_o),
    .mwe_o      (mwe_o),
    .maddr_o    (maddr_o),
    .mwdata_o   (mwdata_o),
    .mack_i     (mack_i),
    .mrdata_i   (mrdata_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_stall", stall_o, 0);
    check("rst_mreq", mreq_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_err", err_o, 0);
    check("rst_maddr", maddr_o, 0);
    tick();
    rst_i = 1'b0;
    // read 0x40, ack in the fourth WAIT cycle
    mem_read_i = 1'b1;
    addr_i = 32'h40;
    sc = 0;
    rc = 0;
    for (int i = 0; i < 5; i++) begin
      mack_i = i == 4;
      mrdata_i = i == 4 ? 32'h1234_5678 : 32'h0;
      @(negedge clk_i);
      sc += int'(stall_o);
      rc += int'(rvalid_o);
      if (i == 0) check("rd_idle_mreq", mreq_o, 0);
      if (i == 1) begin
        check("rd_mreq", mreq_o, 1);
        check("rd_maddr", maddr_o, 32'h40);
        check("rd_mwe", mwe_o, 0);
      end
      tick();
    end
    mem_read_i = 1'b0;
    mack_i = 1'b0;
    addr_i = '0;
    @(negedge clk_i);
    rc += int'(rvalid_o);
    check("rd_rdata", rdata_o, 32'h1234_5678);
    check("rd_done_mreq", mreq_o, 0);
    tick();
    @(negedge clk_i);
    rc += int'(rvalid_o);
    check("rd_stall_cycles", sc, 4);
    check("rd_rvalid_pulses", rc, 1);
    // stray ack while idle
    mack_i = 1'b1;
    mrdata_i = 32'hFFFF_FFFF;
    tick();
    tick();
    mack_i = 1'b0;
    @(negedge clk_i);
    check("stray_rdata", rdata_o, 32'h1234_5678);
    check("stray_rvalid", rvalid_o, 0);
    check("stray_mreq", mreq_o, 0);
    tick();
    // write 0x80 with immediate ack
    mem_write_i = 1'b1;
    addr_i = 32'h80;
    wdata_i = 32'hCAFE_F00D;
    @(negedge clk_i);
    check("wr_idle_stall", stall_o, 1);
    tick();
    mack_i = 1'b1;
    @(negedge clk_i);
    check("wr_mreq", mreq_o, 1);
    check("wr_mwe", mwe_o, 1);
    check("wr_maddr", maddr_o, 32'h80);
    check("wr_mwdata", mwdata_o, 32'hCAFE_F00D);
    check("wr_ack_stall", stall_o, 0);
    tick();
    mem_write_i = 1'b0;
    mack_i = 1'b0;
    addr_i = '0;
    @(negedge clk_i);
    check("wr_done_mreq", mreq_o, 0);
    check("wr_rvalid", rvalid_o, 0);
    check("wr_rdata_kept", rdata_o, 32'h1234_5678);
    tick();
    // misaligned read, then read+write keeps the first error
    mem_read_i = 1'b1;
    addr_i = 32'h41;
    @(negedge clk_i);
    check("mis_stall", stall_o, 0);
    tick();
    check("mis_mreq", mreq_o, 0);
    check("mis_err", err_o, 2'b01);
    mem_write_i = 1'b1;
    addr_i = 32'h40;
    @(negedge clk_i);
    check("rw_stall", stall_o, 0);
    tick();
    check("rw_mreq", mreq_o, 0);
    check("rw_err_sticky", err_o, 2'b01);
    mem_read_i = 1'b0;
    mem_write_i = 1'b0;
    addr_i = '0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst2_err", err_o, 0);
    // read with no ack until timeout
    mem_read_i = 1'b1;
    addr_i = 32'h100;
    tick();
    n = 0;
    stall_last = 1'b1;
    for (int i = 0; i < 40 && mreq_o; i++) begin
      n++;
      @(negedge clk_i);
      stall_last = stall_o;
      tick();
    end
    mem_read_i = 1'b0;
    addr_i = '0;
    check("to_wait_cycles", n, 16);
    check("to_last_stall", stall_last, 0);
    check("to_err", err_o, 2'b11);
    check("to_rdata", rdata_o, 32'hDEAD_BEEF);
    @(negedge clk_i);
    check("to_rvalid", rvalid_o, 1);
    tick();
    check("to_rvalid_end", rvalid_o, 0);
    mem_write_i = 1'b1;
    addr_i = 32'h102;
    tick();
    mem_write_i = 1'b0;
    addr_i = '0;
    check("to_err_sticky", err_o, 2'b11);
    // asynchronous reset in the middle of a WAIT cycle
    mem_read_i = 1'b1;
    addr_i = 32'h200;
    tick();
    @(negedge clk_i);
    check("ar_mreq_before", mreq_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_mreq", mreq_o, 0);
    check("ar_maddr", maddr_o, 0);
    check("ar_rdata", rdata_o, 0);
    check("ar_err", err_o, 0);
    check("ar_rvalid", rvalid_o, 0);
    mem_read_i = 1'b0;
    addr_i = '0;
    tick();
    rst_i = 1'b0;
    rc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      rc += int'(rvalid_o);
    end
    check("ar_no_rvalid", rc, 0);
    check("ar_stall", stall_o, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum WAIT cycles allowed without mack_i before the access is aborted.
REQ-002 Parameter ERR_RDATA, default 32'h0000_0000: value loaded into rdata_o on a timed-out read.
REQ-003 Port clk_i, input, 1: single clock; all state changes on its posedge.
REQ-004 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 Port mem_read_i, input, 1: load request, driven by the EX/MEM register's MemRead output.
REQ-006 Port mem_write_i, input, 1: store request, driven by the EX/MEM register's MemWrite output.
REQ-007 Port addr_i, input, 32: byte address, driven by the EX/MEM register's ALU result.
REQ-008 Port wdata_i, input, 32: store data, driven by the EX/MEM register's write-data output.
REQ-009 Port stall_o, output, 1: freeze request to all upstream pipeline registers.
REQ-010 Port rdata_o, output, 32: load data, registered and held, consumed by MEM/WB.
REQ-011 Port rvalid_o, output, 1: one-cycle pulse when rdata_o is updated.
REQ-012 Port err_o, output, 2: sticky error cause (00 none, 01 misalign, 10 read+write, 11 timeout).
REQ-013 Port mreq_o, output, 1: request to the backing memory.
REQ-014 Port mwe_o, output, 1: write enable accompanying mreq_o.
REQ-015 Port maddr_o, output, 32: word-aligned address to the backing memory.
REQ-016 Port mwdata_o, output, 32: store data to the backing memory.
REQ-017 Port mack_i, input, 1: backing-memory acknowledge, sampled at posedge.
REQ-018 Port mrdata_i, input, 32: backing-memory read data, valid in the mack_i cycle.

Function
REQ-019 States SHALL be IDLE and WAIT only.
REQ-020 An access is valid when exactly one of mem_read_i/mem_write_i is high and addr_i[1:0]==2'b00.
REQ-021 IDLE with a valid access: stall_o=1 combinationally; next posedge latches addr/wdata/we and enters WAIT.
REQ-022 WAIT: mreq_o=1; mwe_o, maddr_o and mwdata_o SHALL be stable from the latched values until the request ends.
REQ-023 WAIT: stall_o = !mack_i, so the pipeline advances on the same edge that samples the ack.
REQ-024 WAIT with mack_i=1 at posedge: return to IDLE; for a read, load rdata_o <= mrdata_i and pulse rvalid_o next cycle.
REQ-025 Access latency: minimum 2 cycles (1 IDLE cycle plus 1 WAIT cycle with immediate ack); no back-to-back issue without passing through IDLE.
REQ-026 Misaligned address or read+write both high: no memory request, stall_o=0, err_o set to 01 or 10 respectively; misalign takes precedence.
REQ-027 Timeout counter: cleared on WAIT entry, incremented each WAIT cycle without ack.
REQ-028 Timeout: when the count reaches TIMEOUT-1 without ack, return to IDLE, drop mreq_o, release stall_o, set err_o=11, and for a read load ERR_RDATA with an rvalid_o pulse.
REQ-029 err_o is sticky: the first error wins and is cleared only by reset.
REQ-030 mack_i seen in IDLE SHALL be ignored.
REQ-031 rdata_o SHALL hold its value between loads; stores never alter it.

Reset
REQ-032 Reset values: state=IDLE, mreq_o=0, mwe_o=0, maddr_o=0, mwdata_o=0, rdata_o=0, rvalid_o=0, err_o=00, timeout count=0.
REQ-033 Reset asserted in WAIT SHALL drop mreq_o asynchronously and abandon the access with no rvalid_o pulse.
REQ-034 stall_o after reset follows the IDLE rule of REQ-021.

Structure
REQ-035 Shared package mem_ctrl_pkg SHALL hold the state enum, the err_o code constants, and the TIMEOUT default.
REQ-036 One sub-module mem_timeout_cnt SHALL implement the clearable saturating counter with its expiry flag.

Verification
REQ-037 Read addr 0x40, mack_i after 3 WAIT cycles with mrdata_i=0x1234_5678 -> stall_o high for 4 cycles, rdata_o=0x1234_5678, single rvalid_o pulse.
REQ-038 Write addr 0x80, wdata 0xCAFE_F00D, immediate ack -> one mreq_o cycle with mwe_o=1 and stable data; rvalid_o stays 0.
REQ-039 Read addr 0x41 -> no mreq_o, stall_o=0, err_o=01; a following read+write -> err_o stays 01.
REQ-040 Read, no ack, TIMEOUT=16 -> mreq_o drops after 16 WAIT cycles, err_o=11, rdata_o=ERR_RDATA, rvalid_o pulses.
REQ-041 rst_i asserted mid-WAIT (between clock edges) -> mreq_o=0 immediately, all outputs at reset values, no rvalid_o.
REQ-042 Stray mack_i in IDLE -> no state change, rdata_o unchanged.
